clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning width of the programmable half-period count.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, meaning the half-period count in effect after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: run enable for all divided outputs.
REQ-006 SHALL have port cfg_valid, input, 1 bit: new divider value offered.
REQ-007 SHALL have port cfg_div, input, DIV_W bits: requested half-period count, in clk cycles.
REQ-008 SHALL have port cfg_ready, output, 1 bit: block can accept a new divider value.
REQ-009 SHALL have port clk_div2, output, 1 bit: registered clk/2.
REQ-010 SHALL have port clk_div4, output, 1 bit: registered clk/4.
REQ-011 SHALL have port clk_divn, output, 1 bit: programmable divided clock with period 2*cur_div clk cycles.
REQ-012 SHALL have port tick, output, 1 bit: one-cycle pulse marking each clk_divn rising transition.

Function
REQ-013 SHALL drive all outputs from flops only, with no combinational path from any input to any output.
REQ-014 With en=1, clk_div2 SHALL toggle on every clk edge.
REQ-015 With en=1, clk_div4 SHALL toggle on each edge where clk_div2 is 1.
REQ-016 SHALL keep internal cur_div (DIV_W bits); a value of 0 SHALL be treated as 1 wherever it is used.
REQ-017 With en=1, counter cnt SHALL step 0..cur_div-1; at cnt==cur_div-1, cnt SHALL go to 0 and clk_divn SHALL toggle.
REQ-018 tick SHALL be 1 for exactly one cycle, on the same edge that clk_divn goes 0->1, and 0 otherwise.
REQ-019 A handshake SHALL complete on an edge where cfg_valid=1 and cfg_ready=1; cfg_div is then captured into a pending register and cfg_ready SHALL go 0 on that edge.
REQ-020 While a value is pending with en=1, it SHALL be applied at the period boundary: the edge where cnt==cur_div-1 and clk_divn==0. On that edge cur_div<=pending and cnt<=0, and clk_divn still rises using the old count.
REQ-021 cfg_ready SHALL return to 1 on the same edge the pending value is applied.
REQ-022 Only one value SHALL ever be pending; cfg_valid while cfg_ready=0 SHALL be ignored with no state change.
REQ-023 With en=0, cnt, clk_div2, clk_div4, clk_divn and tick SHALL clear on the next edge.
REQ-024 With en=0 and a value pending, it SHALL be applied on the next edge, and cfg_ready SHALL return to 1 on that edge.
REQ-025 On an en 0->1 transition, counting SHALL restart from cnt=0 with all divided outputs at 0.
REQ-026 Configuration changes SHALL never truncate a half-period already in progress.

Reset
REQ-027 On rst=0, the block SHALL immediately, without waiting for a clk edge, set: cnt=0; clk_div2, clk_div4, clk_divn, tick=0; cfg_ready=1; pending cleared; cur_div=DEFAULT_DIV.
REQ-028 Reset asserted mid-period or with a value pending SHALL discard the pending value; the first edge after rst deasserts SHALL behave as the first enabled cycle.

Verification
REQ-029 Release reset, en=1, no config -> clk_div2 period 2, clk_div4 period 4; clk_divn first rises on the 4th edge with tick high on that edge, period 8 thereafter.
REQ-030 Offer cfg_div=2 at cnt=1 of a low half (divn period 8) -> cfg_ready 0 from the next edge to the boundary; divn completes the 4-cycle low half and rises; period becomes 4 from then on; cfg_ready 1 on the boundary edge.
REQ-031 Apply cfg_div=0 -> clk_divn toggles every edge (period 2); tick on every second edge.
REQ-032 Drop en for 3 cycles mid high-half -> all divided outputs and tick are 0 one edge later; after en returns, the first rise comes after cur_div edges.
REQ-033 en=0, offer cfg_div=6 -> applied and cfg_ready=1 on the next edge; after en=1, divn period is 12.
REQ-034 Assert rst low between clk edges with a value pending -> outputs 0 and cfg_ready 1 before the next edge; after release, divn period is 8 (DEFAULT_DIV=4).

Source files
------------

// File: rtl/clk_div_gen.sv
// clk_div_gen: fixed clk/2 and clk/4 outputs plus a programmable divider whose
// new half-period count is only adopted at a period boundary, so no half-period is cut short.
module clk_div_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_div2,
    output logic             clk_div4,
    output logic             clk_divn,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_q, pend_d, last_cnt;
    logic div2_q, div2_d, div4_q, div4_d, divn_q, divn_d, tick_q, tick_d, ready_q, ready_d;
    logic wrap, apply, hs;

    always_comb begin
        last_cnt = (cur_q == '0) ? '0 : cur_q - 1'b1;
        wrap     = cnt_q == last_cnt;
        // a pending value lands at the end of a low half, or at once while stopped
        apply    = !ready_q && (!en || (wrap && !divn_q));
        hs       = cfg_valid && ready_q;
        cnt_d    = (!en || wrap) ? '0 : cnt_q + 1'b1;
        div2_d   = en && !div2_q;
        div4_d   = en && (div4_q ^ div2_q);
        divn_d   = en && (divn_q ^ wrap);
        tick_d   = en && wrap && !divn_q;
        cur_d    = apply ? pend_q : cur_q;
        pend_d   = hs ? cfg_div : pend_q;
        ready_d  = apply ? 1'b1 : hs ? 1'b0 : ready_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            cur_q   <= DIV_W'(DEFAULT_DIV);
            pend_q  <= '0;
            div2_q  <= 1'b0;
            div4_q  <= 1'b0;
            divn_q  <= 1'b0;
            tick_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            div2_q  <= div2_d;
            div4_q  <= div4_d;
            divn_q  <= divn_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
        end
    end

    assign cfg_ready = ready_q;
    assign clk_div2  = div2_q;
    assign clk_div4  = div4_q;
    assign clk_divn  = divn_q;
    assign tick      = tick_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed scenarios and random traffic for clk_div_gen, checked
// against an edge-count model of the divider (toggle when a half-period of edges has elapsed).
module tb_clk_div_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready, clk_div2, clk_div4, clk_divn, tick;

    int n_checks = 0;
    int n_fail   = 0;

    int   m_n = 0, m_last = 0, m_h = 4, m_pend = 0;
    logic m_ready = 1'b1, m_divn = 1'b0, m_tick = 1'b0, m_div2 = 1'b0, m_div4 = 1'b0;

    clk_div_gen #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .clk_div2(clk_div2), .clk_div4(clk_div4),
        .clk_divn(clk_divn), .tick(tick)
    );

    always #5 clk = ~clk;

    // reference: m_n counts enabled edges; clk_divn flips once m_h edges pass since the last flip
    always @(posedge clk or negedge rst) begin
        logic hs;
        if (!rst) begin
            m_n = 0; m_last = 0; m_h = 4; m_ready = 1'b1;
            m_divn = 1'b0; m_tick = 1'b0; m_div2 = 1'b0; m_div4 = 1'b0;
        end else begin
            hs = cfg_valid && m_ready;
            if (!en) begin
                m_n = 0; m_last = 0;
                m_divn = 1'b0; m_tick = 1'b0; m_div2 = 1'b0; m_div4 = 1'b0;
                if (!m_ready) begin
                    m_h = m_pend;
                    m_ready = 1'b1;
                end
            end else begin
                m_n++;
                m_div2 = (m_n % 2) == 1;
                m_div4 = ((m_n / 2) % 2) == 1;
                m_tick = 1'b0;
                if (m_n - m_last == ((m_h == 0) ? 1 : m_h)) begin
                    m_tick = !m_divn;
                    if (!m_divn && !m_ready) begin
                        m_h = m_pend;
                        m_ready = 1'b1;
                    end
                    m_divn = !m_divn;
                    m_last = m_n;
                end
            end
            if (hs) begin
                m_pend = int'(cfg_div);
                m_ready = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({clk_div2, clk_div4, clk_divn, tick, cfg_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected 00001", {clk_div2, clk_div4, clk_divn, tick, cfg_ready});
        end
        step();
        n_checks++;
        if ({clk_div2, clk_div4, clk_divn, tick, cfg_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected 00001", {clk_div2, clk_div4, clk_divn, tick, cfg_ready});
        end
        rst = 1'b1;
    endtask

    task automatic test_default();
        int first_rise = 0, second_rise = 0;
        en = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            n_checks++;
            if ({clk_div2, clk_div4, clk_divn, tick, cfg_ready} !== {m_div2, m_div4, m_divn, m_tick, m_ready}) begin
                n_fail++;
                $display("FAIL default_e%0d: got %b expected %b", e, {clk_div2, clk_div4, clk_divn, tick, cfg_ready}, {m_div2, m_div4, m_divn, m_tick, m_ready});
            end
            if (tick && first_rise == 0) first_rise = e;
            else if (tick && second_rise == 0) second_rise = e;
        end
        n_checks++;
        if (first_rise != 4 || second_rise != 12) begin
            n_fail++;
            $display("FAIL default_rise: got %0d,%0d expected 4,12", first_rise, second_rise);
        end
    endtask

    task automatic test_reconfig();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        cfg_valid = 1'b1;
        cfg_div = 8'd2;
        for (int e = 2; e <= 14; e++) begin
            step();
            cfg_div = 8'd7;
            if (e == 3) cfg_valid = 1'b0;
            n_checks++;
            if ({clk_divn, tick, cfg_ready} !== {m_divn, m_tick, m_ready}) begin
                n_fail++;
                $display("FAIL reconfig_model_e%0d: got %b expected %b", e, {clk_divn, tick, cfg_ready}, {m_divn, m_tick, m_ready});
            end
            n_checks++;
            if (tick !== (e % 4 == 0) || cfg_ready !== (e >= 4) || clk_divn !== (e >= 4 && (e % 4) < 2)) begin
                n_fail++;
                $display("FAIL reconfig_e%0d: divn/tick/ready got %b%b%b expected %b%b%b", e, clk_divn, tick, cfg_ready,
                         (e >= 4 && (e % 4) < 2), (e % 4 == 0), (e >= 4));
            end
        end
    endtask

    task automatic test_div_zero();
        en = 1'b0;
        cfg_valid = 1'b1;
        cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        step();
        en = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            n_checks++;
            if (clk_divn !== (e % 2 == 1) || tick !== (e % 2 == 1) || clk_divn !== m_divn || tick !== m_tick) begin
                n_fail++;
                $display("FAIL div_zero_e%0d: divn/tick got %b%b expected %b%b", e, clk_divn, tick, (e % 2 == 1), (e % 2 == 1));
            end
        end
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        cfg_valid = 1'b1;
        cfg_div = 8'd3;
        step();
        cfg_valid = 1'b0;
        step();
        en = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            n_checks++;
            if ({clk_div2, clk_div4, clk_divn, tick} !== {m_div2, m_div4, m_divn, m_tick} || tick !== (e == 3)) begin
                n_fail++;
                $display("FAIL en_pre_e%0d: got %b expected %b", e, {clk_div2, clk_div4, clk_divn, tick}, {m_div2, m_div4, m_divn, m_tick});
            end
        end
        en = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            step();
            n_checks++;
            if ({clk_div2, clk_div4, clk_divn, tick, cfg_ready} !== 5'b00001) begin
                n_fail++;
                $display("FAIL en_off_d%0d: got %b expected 00001", d, {clk_div2, clk_div4, clk_divn, tick, cfg_ready});
            end
        end
        en = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (clk_divn !== (e >= 3 && e <= 5) || tick !== (e == 3) || clk_divn !== m_divn) begin
                n_fail++;
                $display("FAIL en_resume_e%0d: divn/tick got %b%b expected %b%b", e, clk_divn, tick, (e >= 3 && e <= 5), (e == 3));
            end
        end
    endtask

    task automatic test_cfg_disabled();
        en = 1'b0;
        step();
        cfg_valid = 1'b1;
        cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_dis_pending: cfg_ready got %b expected 0", cfg_ready);
        end
        step();
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_dis_applied: cfg_ready got %b expected 1", cfg_ready);
        end
        en = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            n_checks++;
            if (tick !== (e % 12 == 6) || clk_divn !== m_divn || tick !== m_tick) begin
                n_fail++;
                $display("FAIL cfg_dis_e%0d: divn/tick got %b%b expected %b%b", e, clk_divn, tick, m_divn, (e % 12 == 6));
            end
        end
    endtask

    task automatic test_async_reset();
        step();
        cfg_valid = 1'b1;
        cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_pending: cfg_ready got %b expected 0", cfg_ready);
        end
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if ({clk_div2, clk_div4, clk_divn, tick, cfg_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL areset_mid: got %b expected 00001", {clk_div2, clk_div4, clk_divn, tick, cfg_ready});
        end
        step();
        rst = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            n_checks++;
            if (tick !== (e % 8 == 4) || {clk_div2, clk_div4, clk_divn, tick, cfg_ready} !== {m_div2, m_div4, m_divn, m_tick, m_ready}) begin
                n_fail++;
                $display("FAIL areset_after_e%0d: got %b expected %b", e, {clk_div2, clk_div4, clk_divn, tick, cfg_ready}, {m_div2, m_div4, m_divn, m_tick, m_ready});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 19) != 0);
            cfg_valid = ($urandom_range(0, 4) == 0);
            cfg_div = 8'($urandom_range(0, 9));
            step();
            n_checks++;
            if ({clk_div2, clk_div4, clk_divn, tick, cfg_ready} !== {m_div2, m_div4, m_divn, m_tick, m_ready}) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b expected %b", c, {clk_div2, clk_div4, clk_divn, tick, cfg_ready}, {m_div2, m_div4, m_divn, m_tick, m_ready});
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_reconfig();
        test_div_zero();
        test_en_drop();
        test_cfg_disabled();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
